// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: kernel ap_vld/ap_ack stream -> credit-gated 49-bit BFT packets to one leaf/port.
// Optional last-packet replay is compiled in when LEAF_PACKETIZER_RESEND_EN is defined.

package leaf_stream_packetizer_pkg;
  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned NUM_LEAF_BITS = 5;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned NUM_ADDR_BITS = 7;
  localparam int unsigned PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int unsigned CREDIT_BITS   = 8;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } bft_pkt_t;
endpackage

module leaf_stream_packetizer
  import leaf_stream_packetizer_pkg::*;
#(
  parameter int unsigned DEST_LEAF    = 2,
  parameter int unsigned DEST_PORT    = 1,
  parameter int unsigned INIT_CREDITS = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_user,
  input  logic                    vld_user,
  output logic                    ack_user,
  input  logic [PACKET_BITS-1:0]  din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]  dout_leaf_interface2bft,
  input  logic                    resend,
  output logic [CREDIT_BITS-1:0]  credit_count,
  output logic                    err_unexpected
);

  localparam int unsigned SUM_BITS   = CREDIT_BITS + 2;
  localparam int unsigned CREDIT_MAX = 1 << NUM_ADDR_BITS;

`ifdef LEAF_PACKETIZER_RESEND_EN
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, REPLAY = 2'd2} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;
`endif

  state_t                   state;
  logic [NUM_ADDR_BITS-1:0] addr;

  bft_pkt_t                 in_pkt_c;
  bft_pkt_t                 tx_pkt_c;
  logic                     xfer_c;
  logic                     is_credit_c;
  logic                     is_unexpected_c;
  logic [SUM_BITS-1:0]      credit_sum_c;
  logic [CREDIT_BITS-1:0]   credit_next_c;
  logic                     unused_c;

`ifdef LEAF_PACKETIZER_RESEND_EN
  bft_pkt_t                 shadow;
  logic                     shadow_vld;

  assign ack_user = reset && (credit_count != '0) && (state != REPLAY);
  assign unused_c = ^{in_pkt_c.addr, in_pkt_c.payload[PAYLOAD_BITS-1:8]};
`else
  // State tracks credit!=0 exactly, so RUN alone gates the kernel.
  assign ack_user = reset && (state == RUN);
  assign unused_c = ^{in_pkt_c.addr, in_pkt_c.payload[PAYLOAD_BITS-1:8], resend};
`endif

  assign in_pkt_c = din_leaf_bft2interface;
  assign xfer_c   = vld_user && ack_user;

  // Outgoing packet and inbound classification / credit arithmetic.
  always_comb begin
    tx_pkt_c.valid   = 1'b1;
    tx_pkt_c.leaf    = NUM_LEAF_BITS'(DEST_LEAF);
    tx_pkt_c.port    = NUM_PORT_BITS'(DEST_PORT);
    tx_pkt_c.addr    = addr;
    tx_pkt_c.payload = din_user;

    is_credit_c     = in_pkt_c.valid && (in_pkt_c.port == '0) &&
                      (in_pkt_c.leaf == NUM_LEAF_BITS'(DEST_LEAF));
    is_unexpected_c = in_pkt_c.valid && !is_credit_c;

    credit_sum_c = SUM_BITS'(credit_count) - SUM_BITS'(xfer_c);
    if (is_credit_c) begin
      credit_sum_c = credit_sum_c + SUM_BITS'(in_pkt_c.payload[7:0]);
    end
    if (credit_sum_c > SUM_BITS'(CREDIT_MAX)) begin
      credit_next_c = CREDIT_BITS'(CREDIT_MAX);
    end else begin
      credit_next_c = credit_sum_c[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_leaf_interface2bft <= '0;
      credit_count            <= CREDIT_BITS'(INIT_CREDITS);
      addr                    <= '0;
      err_unexpected          <= 1'b0;
      state                   <= (INIT_CREDITS == 0) ? STALL : RUN;
`ifdef LEAF_PACKETIZER_RESEND_EN
      shadow                  <= '0;
      shadow_vld              <= 1'b0;
`endif
    end else begin
      err_unexpected <= is_unexpected_c;
      credit_count   <= credit_next_c;
      state          <= (credit_next_c == '0) ? STALL : RUN;
      if (xfer_c) begin
        dout_leaf_interface2bft <= tx_pkt_c;
        addr                    <= addr + NUM_ADDR_BITS'(1);
      end else begin
        dout_leaf_interface2bft <= '0;
      end
`ifdef LEAF_PACKETIZER_RESEND_EN
      if (xfer_c) begin
        shadow     <= tx_pkt_c;
        shadow_vld <= 1'b1;
      end
      // REPLAY lasts one cycle; a resend seen while replaying is dropped.
      if (state == REPLAY) begin
        dout_leaf_interface2bft <= shadow;
      end else if (resend && (shadow_vld || xfer_c)) begin
        state <= REPLAY;
      end
`endif
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Randomized self-checking bench for leaf_stream_packetizer against a credit/sequence reference model.
module tb_leaf_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_user;
  logic        vld_user;
  logic        ack_user;
  logic [48:0] din_leaf;
  logic [48:0] dout;
  logic        resend;
  logic [7:0]  credit_count;
  logic        err_unexpected;

  logic [31:0] s_din;
  logic        s_vld;
  logic        s_ack;
  logic [48:0] s_leaf_in;
  logic [48:0] s_dout;
  logic        s_resend;
  logic [7:0]  s_credit;
  logic        s_err;

  int checks   = 0;
  int failures = 0;

  int          m_credit;
  int          m_addr;
  logic [48:0] exp_dout;
  logic        exp_err;
  logic        exp_ack;

  always #5 clk = ~clk;

  leaf_stream_packetizer #(.DEST_LEAF(2), .DEST_PORT(1), .INIT_CREDITS(64)) dut (
    .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .din_leaf_bft2interface(din_leaf), .dout_leaf_interface2bft(dout), .resend(resend),
    .credit_count(credit_count), .err_unexpected(err_unexpected));

  leaf_stream_packetizer #(.DEST_LEAF(2), .DEST_PORT(1), .INIT_CREDITS(2)) dut_small (
    .clk(clk), .reset(reset), .din_user(s_din), .vld_user(s_vld), .ack_user(s_ack),
    .din_leaf_bft2interface(s_leaf_in), .dout_leaf_interface2bft(s_dout), .resend(s_resend),
    .credit_count(s_credit), .err_unexpected(s_err));

  function automatic logic [48:0] exp_pkt(input int a, input logic [31:0] d);
    return {1'b1, 5'd2, 4'd1, 7'(a), d};
  endfunction

  function automatic logic [48:0] credit_pkt(input int inc);
    return {1'b1, 5'd2, 4'd0, 7'($urandom), 24'($urandom), 8'(inc)};
  endfunction

  function automatic logic [48:0] bad_pkt();
    int lf;
    if ($urandom_range(0, 1) == 0)
      return {1'b1, 5'd2, 4'($urandom_range(1, 15)), 7'($urandom), 32'($urandom)};
    lf = $urandom_range(0, 30);
    if (lf >= 2) lf = lf + 1;
    return {1'b1, 5'(lf), 4'd0, 7'($urandom), 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: credits gate sends, each send uses one credit and the next sequence number,
  // credit returns add din[7:0], total capped at 128.
  task automatic model_step(input logic v, input logic [31:0] d, input logic [48:0] ip);
    bit xf;
    bit isc;
    int inc;
    exp_ack  = (m_credit != 0);
    xf       = v && exp_ack;
    isc      = ip[48] && (ip[42:39] == 4'd0) && (ip[47:43] == 5'd2);
    inc      = isc ? int'(ip[7:0]) : 0;
    exp_err  = ip[48] && !isc;
    exp_dout = xf ? exp_pkt(m_addr, d) : 49'd0;
    m_credit = m_credit - int'(xf) + inc;
    if (m_credit > 128) m_credit = 128;
    if (xf) m_addr = (m_addr + 1) % 128;
  endtask

  task automatic test_reset();
    reset = 1'b0; vld_user = 1'b0; din_user = '0; din_leaf = '0; resend = 1'b0;
    s_vld = 1'b0; s_din = '0; s_leaf_in = '0; s_resend = 1'b0;
    tick(); tick();
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (credit_count !== 8'd64) begin failures++; $display("FAIL reset_credit got=%0d exp=64", credit_count); end
    checks++; if (err_unexpected !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_unexpected); end
    checks++; if (ack_user !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_user); end
    checks++; if (s_credit !== 8'd2) begin failures++; $display("FAIL reset_small_credit got=%0d exp=2", s_credit); end
    reset = 1'b1;
    #1;
    checks++; if (ack_user !== 1'b1) begin failures++; $display("FAIL reset_release_ack got=%b exp=1", ack_user); end
    m_credit = 64; m_addr = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      vld_user = 1'b1; din_user = 32'hA5A5_0001 + 32'(i); din_leaf = '0;
      #1;
      checks++; if (ack_user !== 1'b1) begin failures++; $display("FAIL basic_ack%0d got=%b exp=1", i, ack_user); end
      m_credit = m_credit - 1; m_addr = m_addr + 1;
      @(posedge clk); #1;
      checks++; if (dout !== exp_pkt(i, 32'hA5A5_0001 + 32'(i))) begin failures++; $display("FAIL basic_dout%0d got=%h exp=%h", i, dout, exp_pkt(i, 32'hA5A5_0001 + 32'(i))); end
      checks++; if (credit_count !== 8'(63 - i)) begin failures++; $display("FAIL basic_credit%0d got=%0d exp=%0d", i, credit_count, 63 - i); end
    end
    vld_user = 1'b0;
    tick();
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL basic_idle got=%h exp=0", dout); end
  endtask

  task automatic test_stall_small();
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    s_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_din = w[i];
      #1;
      checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL small_ack%0d got=%b exp=1", i, s_ack); end
      @(posedge clk); #1;
      checks++; if (s_dout !== exp_pkt(i, w[i])) begin failures++; $display("FAIL small_dout%0d got=%h exp=%h", i, s_dout, exp_pkt(i, w[i])); end
    end
    s_din = w[2];
    #1;
    checks++; if (s_ack !== 1'b0) begin failures++; $display("FAIL small_stall_ack got=%b exp=0", s_ack); end
    tick();
    checks++; if (s_dout !== 49'd0) begin failures++; $display("FAIL small_stall_dout got=%h exp=0", s_dout); end
    checks++; if (s_credit !== 8'd0) begin failures++; $display("FAIL small_stall_credit got=%0d exp=0", s_credit); end
    s_leaf_in = credit_pkt(1);
    tick();
    s_leaf_in = '0;
    checks++; if (s_credit !== 8'd1) begin failures++; $display("FAIL small_return_credit got=%0d exp=1", s_credit); end
    checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL small_return_ack got=%b exp=1", s_ack); end
    tick();
    checks++; if (s_dout !== exp_pkt(2, w[2])) begin failures++; $display("FAIL small_third got=%h exp=%h", s_dout, exp_pkt(2, w[2])); end
    s_vld = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      vld_user = ($urandom_range(0, 9) < 7);
      din_user = $urandom;
      r = $urandom_range(0, 9);
      if (r < 2)       din_leaf = credit_pkt($urandom_range(0, 6));
      else if (r == 2) din_leaf = bad_pkt();
      else if (r == 3) din_leaf = {1'b0, 16'($urandom), 32'($urandom)};
      else             din_leaf = '0;
      model_step(vld_user, din_user, din_leaf);
      #1;
      checks++; if (ack_user !== exp_ack) begin failures++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, ack_user, exp_ack); end
      tick();
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rand_dout c=%0d got=%h exp=%h", c, dout, exp_dout); end
      checks++; if (credit_count !== 8'(m_credit)) begin failures++; $display("FAIL rand_credit c=%0d got=%0d exp=%0d", c, credit_count, m_credit); end
      checks++; if (err_unexpected !== exp_err) begin failures++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, err_unexpected, exp_err); end
    end
    din_leaf = '0; vld_user = 1'b0;
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 130; c++) begin
      vld_user = 1'b1; din_user = 32'h0BAD_0000 + 32'(c); din_leaf = credit_pkt(1);
      model_step(vld_user, din_user, din_leaf);
      tick();
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL wrap_dout c=%0d got=%h exp=%h", c, dout, exp_dout); end
      checks++; if (credit_count !== 8'(m_credit)) begin failures++; $display("FAIL wrap_credit c=%0d got=%0d exp=%0d", c, credit_count, m_credit); end
    end
    vld_user = 1'b0; din_leaf = '0;
  endtask

  task automatic test_boundary();
    for (int c = 0; c < 300 && m_credit != 10; c++) begin
      vld_user = (m_credit > 10); din_user = $urandom;
      din_leaf = (m_credit < 10) ? credit_pkt(1) : 49'd0;
      model_step(vld_user, din_user, din_leaf);
      tick();
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL bnd_drain_dout c=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    vld_user = 1'b1; din_user = 32'hCAFE_0010; din_leaf = credit_pkt(4);
    model_step(vld_user, din_user, din_leaf);
    tick();
    checks++; if (credit_count !== 8'd13) begin failures++; $display("FAIL bnd_same_cycle got=%0d exp=13", credit_count); end
    checks++; if (dout !== exp_dout) begin failures++; $display("FAIL bnd_same_cycle_dout got=%h exp=%h", dout, exp_dout); end
    vld_user = 1'b0; din_leaf = credit_pkt(200);
    model_step(vld_user, din_user, din_leaf);
    tick();
    checks++; if (credit_count !== 8'd128) begin failures++; $display("FAIL bnd_saturate got=%0d exp=128", credit_count); end
    vld_user = 1'b1; din_leaf = credit_pkt(1);
    model_step(vld_user, din_user, din_leaf);
    tick();
    checks++; if (credit_count !== 8'd128) begin failures++; $display("FAIL bnd_full_send_return got=%0d exp=128", credit_count); end
    vld_user = 1'b0; din_leaf = credit_pkt(5);
    model_step(vld_user, din_user, din_leaf);
    tick();
    din_leaf = '0;
    checks++; if (credit_count !== 8'd128) begin failures++; $display("FAIL bnd_at_max got=%0d exp=128", credit_count); end
  endtask

  task automatic test_unexpected();
    din_leaf = {1'b1, 5'd2, 4'd3, 7'd0, 32'h0000_0040};
    model_step(1'b0, 32'd0, din_leaf);
    tick();
    din_leaf = '0;
    checks++; if (err_unexpected !== 1'b1) begin failures++; $display("FAIL unexp_pulse got=%b exp=1", err_unexpected); end
    checks++; if (credit_count !== 8'(m_credit)) begin failures++; $display("FAIL unexp_credit got=%0d exp=%0d", credit_count, m_credit); end
    model_step(1'b0, 32'd0, din_leaf);
    tick();
    checks++; if (err_unexpected !== 1'b0) begin failures++; $display("FAIL unexp_clear got=%b exp=0", err_unexpected); end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 2; i++) begin
      vld_user = 1'b1; din_user = $urandom; din_leaf = credit_pkt(2);
      model_step(vld_user, din_user, din_leaf);
      tick();
    end
    din_leaf = '0;
    reset = 1'b0; din_user = 32'h7777_0000;
    #1;
    checks++; if (ack_user !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", ack_user); end
    tick();
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL midrst_dout got=%h exp=0", dout); end
    checks++; if (credit_count !== 8'd64) begin failures++; $display("FAIL midrst_credit got=%0d exp=64", credit_count); end
    reset = 1'b1; m_credit = 64; m_addr = 0;
    din_user = 32'h7777_0001;
    tick();
    checks++; if (dout !== exp_pkt(0, 32'h7777_0001)) begin failures++; $display("FAIL midrst_first got=%h exp=%h", dout, exp_pkt(0, 32'h7777_0001)); end
    m_credit = 63; m_addr = 1;
    vld_user = 1'b0;
    tick();
  endtask

`ifdef LEAF_PACKETIZER_RESEND_EN
  task automatic test_resend();
    reset = 1'b0; vld_user = 1'b0; din_leaf = '0; resend = 1'b0;
    tick();
    reset = 1'b1; m_credit = 64; m_addr = 0;
    resend = 1'b1;
    tick();
    resend = 1'b0;
    #1;
    checks++; if (ack_user !== 1'b1) begin failures++; $display("FAIL resend_noop_ack got=%b exp=1", ack_user); end
    for (int i = 0; i < 6; i++) begin
      vld_user = 1'b1; din_user = (i == 5) ? 32'h0000_1234 : 32'(i);
      model_step(vld_user, din_user, din_leaf);
      tick();
    end
    vld_user = 1'b0; resend = 1'b1;
    tick();
    checks++; if (ack_user !== 1'b0) begin failures++; $display("FAIL resend_replay_ack got=%b exp=0", ack_user); end
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL resend_gap got=%h exp=0", dout); end
    tick();
    resend = 1'b0;
    #1;
    checks++; if (dout !== exp_pkt(5, 32'h0000_1234)) begin failures++; $display("FAIL resend_dout got=%h exp=%h", dout, exp_pkt(5, 32'h0000_1234)); end
    checks++; if (credit_count !== 8'(m_credit)) begin failures++; $display("FAIL resend_credit got=%0d exp=%0d", credit_count, m_credit); end
    checks++; if (ack_user !== 1'b1) begin failures++; $display("FAIL resend_back_ack got=%b exp=1", ack_user); end
  endtask
`else
  task automatic test_resend();
    resend = 1'b1; vld_user = 1'b0; din_leaf = '0;
    tick();
    resend = 1'b0;
    #1;
    checks++; if (ack_user !== 1'b1) begin failures++; $display("FAIL resend_ignored_ack got=%b exp=1", ack_user); end
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL resend_ignored_dout got=%h exp=0", dout); end
    tick();
    checks++; if (dout !== 49'd0) begin failures++; $display("FAIL resend_ignored_dout2 got=%h exp=0", dout); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall_small();
    test_random();
    test_wrap();
    test_boundary();
    test_unexpected();
    test_midreset();
    test_resend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
